// File: rtl/mips_test_harness_ctrl.sv
// Test controller for the MIPS Harvard CPU: loadable instruction ROM plus a
// run/halt/check sequencer that drives the CPU reset, watches for the halt,
// and compares register_v0 against an expected value under a mask.
module mips_test_harness_ctrl #(
  parameter int          ROM_DEPTH      = 64,
  parameter logic [31:0] RESET_VECTOR   = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR      = 32'h00000000,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter int          CNT_W          = 16,
  localparam int         AW             = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [31:0]      prog_data,
  input  logic [31:0]      expected_v0,
  input  logic [31:0]      expected_mask,
  input  logic             start,
  output logic             cpu_reset,
  input  logic [31:0]      instr_address,
  output logic [31:0]      instr_readdata,
  input  logic             active,
  input  logic [31:0]      register_v0,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [31:0]      exp_q, exp_d, mask_q, mask_d, v0cap_q, v0cap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d, pass_q, pass_d, fail_q, fail_d, to_q, to_d;

  logic [31:0] rom_q [ROM_DEPTH];
  logic [31:0] off;
  logic        in_rng;
  logic        halt;
  logic        idle_like;

  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
  assign halt      = (instr_address == HALT_ADDR) || !active;

  // ROM read: word index relative to the reset vector, NOP for misaligned or
  // out-of-range fetches (addresses below the vector wrap to huge offsets).
  assign off    = instr_address - RESET_VECTOR;
  assign in_rng = (off[1:0] == 2'b00) && ({2'b00, off[31:2]} < 32'(ROM_DEPTH));
  assign instr_readdata = in_rng ? rom_q[off[AW+1:2]] : 32'h0;

  // CPU is held in reset everywhere except RUN.
  assign cpu_reset   = (state_q != S_RUN);
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = to_q;
  assign cycle_count = cnt_q;

  // Sequencer next-state and flag logic.
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    mask_d  = mask_q;
    v0cap_d = v0cap_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          exp_d   = expected_v0;
          mask_d  = expected_mask;
          cnt_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          to_d    = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        // Halt takes priority over a coincident timeout.
        if (halt) begin
          v0cap_d = register_v0;
          state_d = S_CHECK;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          done_d  = 1'b1;
          to_d    = 1'b1;
          fail_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: begin // S_CHECK
        done_d  = 1'b1;
        pass_d  = ((v0cap_q ^ exp_q) & mask_q) == 32'h0;
        fail_d  = ((v0cap_q ^ exp_q) & mask_q) != 32'h0;
        state_d = S_DONE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      exp_q   <= '0;
      mask_q  <= '0;
      v0cap_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      mask_q  <= mask_d;
      v0cap_q <= v0cap_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      to_q    <= to_d;
    end
  end

  // ROM write port: only while the CPU is not running; contents survive reset.
  always_ff @(posedge clk) begin
    if (prog_we && idle_like) rom_q[prog_addr] <= prog_data;
  end

endmodule

// File: tb/tb_mips_test_harness_ctrl.sv
// Directed bench for mips_test_harness_ctrl; the bench plays the CPU by
// driving fetch addresses, active and register_v0 by hand.
module tb_mips_test_harness_ctrl;
  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset, prog_we, start, active;
  logic [5:0]  prog_addr;
  logic [31:0] prog_data, expected_v0, expected_mask, instr_address, register_v0;
  logic        cpu_reset, done, pass, fail, timeout;
  logic [31:0] instr_readdata;
  logic [15:0] cycle_count;

  int checks = 0;
  int failures = 0;
  logic [31:0] prog [5] = '{32'h2484000B, 32'h24A5004D, 32'h0085102B,
                            32'h00000008, 32'h24000000};

  mips_test_harness_ctrl #(.ROM_DEPTH(64), .RESET_VECTOR(RV), .HALT_ADDR(32'h0),
                           .TIMEOUT_CYCLES(50), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .expected_v0(expected_v0), .expected_mask(expected_mask),
    .start(start), .cpu_reset(cpu_reset), .instr_address(instr_address),
    .instr_readdata(instr_readdata), .active(active), .register_v0(register_v0),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .cycle_count(cycle_count));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [5:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  // Run the 5-word program: fetch each word, jump to 0 with the given v0.
  task automatic run_prog(input string tag, input logic [31:0] exp, input logic [31:0] mask,
                          input logic [31:0] v0, input logic exp_pass);
    expected_v0 = exp; expected_mask = mask; active = 1'b1; instr_address = RV;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_cpu_reset_run"}, 32'(cpu_reset), 32'd0);
    for (int i = 0; i < 5; i++) begin
      instr_address = RV + 32'(4 * i);
      #1;
      chk({tag, "_fetch"}, instr_readdata, prog[i]);
      tick();
    end
    instr_address = 32'h0; register_v0 = v0;
    tick();                                   // halt edge -> CHECK
    chk({tag, "_done_in_check"}, 32'(done), 32'd0);
    chk({tag, "_cpu_reset_check"}, 32'(cpu_reset), 32'd1);
    instr_address = RV;
    tick();                                   // -> DONE
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_pass"}, 32'(pass), 32'(exp_pass));
    chk({tag, "_fail"}, 32'(fail), 32'(!exp_pass));
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_cycles"}, 32'(cycle_count), 32'd6);
  endtask

  initial begin
    int n;
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; start = 1'b0;
    expected_v0 = '0; expected_mask = '0; instr_address = RV; active = 1'b1;
    register_v0 = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_cycles", 32'(cycle_count), 32'd0);

    for (int i = 0; i < 5; i++) load(6'(i), prog[i]);

    // Scenario 1-3: masked compare outcomes
    run_prog("s1", 32'd1, 32'hFFFFFFFF, 32'd1, 1'b1);
    run_prog("s2", 32'd0, 32'hFFFFFFFF, 32'd1, 1'b0);
    run_prog("s3", 32'd0, 32'h00000000, 32'd1, 1'b1);

    // Scenario 4: branch-to-self never halts -> timeout after 50 RUN cycles
    load(6'd0, 32'h1000FFFF);
    expected_v0 = 32'd1; expected_mask = 32'hFFFFFFFF; instr_address = RV;
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!done && n < 60) begin
      #1;
      if (n == 0) chk("s4_fetch", instr_readdata, 32'h1000FFFF);
      tick(); n++;
    end
    chk("s4_latency", 32'(n), 32'd50);
    chk("s4_timeout", 32'(timeout), 32'd1);
    chk("s4_fail", 32'(fail), 32'd1);
    chk("s4_pass", 32'(pass), 32'd0);
    chk("s4_cycles", 32'(cycle_count), 32'd50);
    chk("s4_cpu_reset", 32'(cpu_reset), 32'd1);
    load(6'd0, prog[0]);

    // Scenario 5: NOP for misaligned / out of range, writes ignored in RUN
    instr_address = 32'hBFC00002; #1;
    chk("s5_misaligned", instr_readdata, 32'h0);
    instr_address = RV + 32'd256; #1;
    chk("s5_out_of_range", instr_readdata, 32'h0);
    instr_address = RV + 32'd16; #1;
    chk("s5_last_word", instr_readdata, 32'h24000000);
    instr_address = RV; start = 1'b1; tick(); start = 1'b0;
    load(6'd0, 32'hDEADBEEF);
    #1;
    chk("s5_rom_kept", instr_readdata, 32'h2484000B);
    chk("s5_still_run", 32'(cpu_reset), 32'd0);

    // Scenario 6: reset mid-RUN, then rerun proves ROM retention
    reset = 1'b1; tick(); reset = 1'b0;
    chk("s6_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("s6_done", 32'(done), 32'd0);
    chk("s6_fail", 32'(fail), 32'd0);
    chk("s6_cycles", 32'(cycle_count), 32'd0);
    run_prog("s6", 32'd1, 32'hFFFFFFFF, 32'd1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
